add_bist: RTL



---
 rtl/add_bist_pkg.sv | 26 ++
 rtl/add_golden.sv | 25 ++
 rtl/add_bist.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/add_bist_pkg.sv
// add_bist_pkg
// Shared definitions for the 2-bit adder sweep controller:
//   - W_DEFAULT : default operand width of the adder block under test
//   - state_t   : sweep controller states
//   - vec_width : width of the vector index {a, b, sel}
//   - err_width : width of the saturating error counter
package add_bist_pkg;

  localparam int W_DEFAULT = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic int vec_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int err_width(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/add_golden.sv
// add_golden
// Combinational reference adder used by self-checking blocks.
// Ports:
//   a_i, b_i   in  W  operands
//   exp_sum_o  out W  (a + b) mod 2^W
//   exp_ovf_o  out W  carry-out of a + b in bit 0, upper bits zero
module add_golden #(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] exp_sum_o,
  output logic [W-1:0] exp_ovf_o
);

  logic [W:0] full_sum;

  always_comb begin
    full_sum     = {1'b0, a_i} + {1'b0, b_i};
    exp_sum_o    = full_sum[W-1:0];
    exp_ovf_o    = '0;
    exp_ovf_o[0] = full_sum[W];
  end

endmodule

// File: rtl/add_bist.sv
// add_bist
// Sweep controller that drives every {a, b, sel} combination into the adder
// block, checks its responses against add_golden and reports the result.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begin a sweep (honoured only in IDLE or DONE)
//   in0_add, in1_add   registered operands to the adder block
//   sel                registered path select to the adder block
//   out0_add, out1_add adder block sum / overflow word
//   ok_add             adder block internal agreement flag
//   busy, done         sweep in progress / sweep finished (held)
//   pass               1 iff no vector failed (valid with done)
//   err_count          saturating count of failing vectors
//   first_fail         index of the first failing vector, 0 if none
module add_bist
  import add_bist_pkg::*;
#(
  parameter  int W  = W_DEFAULT,
  localparam int VW = vec_width(W),
  localparam int EW = err_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [W-1:0]  in0_add,
  output logic [W-1:0]  in1_add,
  output logic          sel,
  input  logic [W-1:0]  out0_add,
  input  logic [W-1:0]  out1_add,
  input  logic          ok_add,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_count,
  output logic [VW-1:0] first_fail
);

  state_t        state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;            // doubles as the stimulus register
  logic [EW-1:0] err_count_q, err_count_d;
  logic [VW-1:0] first_fail_q, first_fail_d;
  logic          fail_seen_q, fail_seen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [W-1:0]  exp_sum, exp_ovf;
  logic          vec_fail;
  logic          vec_last;

  // Vector index layout is {a, b, sel}.
  add_golden #(.W(W)) u_golden (
    .a_i       (vec_q[VW-1:W+1]),
    .b_i       (vec_q[W:1]),
    .exp_sum_o (exp_sum),
    .exp_ovf_o (exp_ovf)
  );

  assign vec_fail = !ok_add || (out0_add != exp_sum) || (out1_add != exp_ovf);
  assign vec_last = &vec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_DRIVE;
          vec_d        = '0;
          err_count_d  = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      S_DRIVE: begin
        // Settle cycle: adder responses to the new stimulus are checked next.
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (vec_fail) begin
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!fail_seen_q) begin
            first_fail_d = vec_q;
            fail_seen_d  = 1'b1;
          end
        end
        if (vec_last) begin
          // Stimulus stays on the last vector while results are held.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in0_add    = vec_q[VW-1:W+1];
  assign in1_add    = vec_q[W:1];
  assign sel        = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;

endmodule
